// File: rtl/trivium_ks_ctrl.sv
// Sequencer for an external Trivium keystream core: load, warm-up, then pack
// keystream bits LSB-first into bytes and push them into a byte FIFO.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start; start with num_bytes=0 completes at once
//   LOAD    | core_load pulse, byte count cleared
//   WARMUP  | core_en for WARMUP_CYCLES steps, keystream discarded
//   COLLECT | core_en for 8 steps, core_z shifted into fifo_din
//   PUSH    | core halted; write the byte when the FIFO has space
//   DONE    | one-cycle done pulse
module trivium_ks_ctrl #(
    parameter int WARMUP_CYCLES = 1152,
    parameter int WCNT_W        = 11,
    parameter int LEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] num_bytes,
    output logic             core_load,
    output logic             core_en,
    input  logic             core_z,
    input  logic [1:0]       fifo_condition,
    output logic             fifo_write,
    output logic [7:0]       fifo_din,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bytes_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WARMUP  = 3'd2,
        COLLECT = 3'd3,
        PUSH    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state;
    logic [WCNT_W-1:0]  wcnt;
    logic [2:0]         bcnt;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   bytes_nxt;
    logic               fifo_full;

    assign fifo_full = (fifo_condition == 2'b11);
    assign bytes_nxt = bytes_out + LEN_W'(1);

    // The write strobe must react to the FIFO status in the same cycle, so it
    // is decoded from the state register; rst blocks a write in the reset cycle.
    assign fifo_write = (state == PUSH) && !fifo_full && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            bcnt      <= '0;
            len       <= '0;
            core_load <= 1'b0;
            core_en   <= 1'b0;
            fifo_din  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            bytes_out <= '0;
        end else begin
            core_load <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_bytes != '0) begin
                            len       <= num_bytes;
                            bytes_out <= '0;
                            core_load <= 1'b1;
                            busy      <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            // zero-length request: completes without ever raising busy
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    wcnt    <= WCNT_W'(WARMUP_CYCLES - 1);
                    core_en <= 1'b1;
                    state   <= WARMUP;
                end
                WARMUP: begin
                    if (wcnt == '0) begin
                        bcnt  <= 3'd0;
                        state <= COLLECT;
                    end else begin
                        wcnt <= wcnt - WCNT_W'(1);
                    end
                end
                COLLECT: begin
                    fifo_din <= {core_z, fifo_din[7:1]};
                    bcnt     <= bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        core_en <= 1'b0;
                        state   <= PUSH;
                    end
                end
                PUSH: begin
                    if (!fifo_full) begin
                        bytes_out <= bytes_nxt;
                        if (bytes_nxt == len) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            core_en <= 1'b1;
                            bcnt    <= 3'd0;
                            state   <= COLLECT;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    core_en <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_ks_ctrl.sv
// Bench for trivium_ks_ctrl: a short-warm-up instance for most scenarios and a
// default-parameter instance for the full 1152-step warm-up.
module tb_trivium_ks_ctrl;

    localparam int W     = 4;
    localparam int WD    = 1152;
    localparam int LEN_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, start2;
    logic [LEN_W-1:0] num_bytes, num_bytes2;
    logic [1:0]       fifo_condition;
    logic             core_z1, core_z2;

    logic             core_load1, core_en1, fifo_write1, busy1, done1;
    logic [7:0]       fifo_din1;
    logic [LEN_W-1:0] bytes_out1;
    logic             core_load2, core_en2, fifo_write2, busy2, done2;
    logic [7:0]       fifo_din2;
    logic [LEN_W-1:0] bytes_out2;

    trivium_ks_ctrl #(.WARMUP_CYCLES(W), .WCNT_W(3), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes),
        .core_load(core_load1), .core_en(core_en1), .core_z(core_z1),
        .fifo_condition(fifo_condition), .fifo_write(fifo_write1),
        .fifo_din(fifo_din1), .busy(busy1), .done(done1), .bytes_out(bytes_out1)
    );

    trivium_ks_ctrl dut_def (
        .clk(clk), .rst(rst), .start(start2), .num_bytes(num_bytes2),
        .core_load(core_load2), .core_en(core_en2), .core_z(core_z2),
        .fifo_condition(fifo_condition), .fifo_write(fifo_write2),
        .fifo_din(fifo_din2), .busy(busy2), .done(done2), .bytes_out(bytes_out2)
    );

    // Behavioural core: keystream bit is ks[step mod 64], step counts core_en cycles since load.
    logic [63:0] ks;
    logic [31:0] step1, step2;
    always_ff @(posedge clk) begin
        if (rst || core_load1) step1 <= 32'd0;
        else if (core_en1)     step1 <= step1 + 32'd1;
        if (rst || core_load2) step2 <= 32'd0;
        else if (core_en2)     step2 <= step2 + 32'd1;
    end
    assign core_z1 = ks[step1[5:0]];
    assign core_z2 = ks[step2[5:0]];

    int sel;
    logic o_load, o_en, o_wr, o_done, o_busy;
    logic [7:0] o_din;
    assign o_load = (sel != 0) ? core_load2  : core_load1;
    assign o_en   = (sel != 0) ? core_en2    : core_en1;
    assign o_wr   = (sel != 0) ? fifo_write2 : fifo_write1;
    assign o_done = (sel != 0) ? done2       : done1;
    assign o_busy = (sel != 0) ? busy2       : busy1;
    assign o_din  = (sel != 0) ? fifo_din2   : fifo_din1;

    int errors = 0;
    int checks = 0;
    int cyc, hold_start, stall_lo, stall_hi;
    int n_load, first_load, last_load, n_en, first_en, en_before_wr;
    int n_wr, first_wr, second_wr, last_wr, n_done, first_done, n_busy;
    int en_in_stall, din_changes;
    logic [7:0] din_at_stall, din_first, exp_b;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    function automatic logic [7:0] exp_byte(input int w, input int k);
        logic [7:0] e;
        for (int b = 0; b < 8; b++) e[b] = ks[(w + 8 * k + b) % 64];
        return e;
    endfunction

    task automatic clear_obs();
        cyc = 0; stall_lo = -1; stall_hi = -1;
        n_load = 0; first_load = -1; last_load = -1; n_en = 0; first_en = -1; en_before_wr = 0;
        n_wr = 0; first_wr = -1; second_wr = -1; last_wr = -1; n_done = 0; first_done = -1;
        n_busy = 0; en_in_stall = 0; din_changes = 0; din_first = 8'h00; din_at_stall = 8'h00;
    endtask

    // Advance one cycle: drive inputs just after the edge, observe at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (hold_start == 0) start = 1'b0;
        start2 = 1'b0;
        fifo_condition = (cyc >= stall_lo && cyc <= stall_hi) ? 2'b11 : 2'(cyc % 3);
        @(negedge clk);
        if (o_load) begin n_load++; if (first_load < 0) first_load = cyc; last_load = cyc; end
        if (o_en) begin n_en++; if (first_en < 0) first_en = cyc; if (n_wr == 0) en_before_wr++; end
        if (o_wr) begin
            n_wr++;
            if (n_wr == 1) begin first_wr = cyc; din_first = o_din; end
            if (n_wr == 2) second_wr = cyc;
            last_wr = cyc;
        end
        if (o_done) begin n_done++; if (first_done < 0) first_done = cyc; end
        if (o_busy) n_busy++;
        if (cyc >= stall_lo && cyc <= stall_hi) begin
            if (o_en) en_in_stall++;
            if (cyc == stall_lo) din_at_stall = o_din;
            else if (o_din !== din_at_stall) din_changes++;
        end
        if (fifo_write1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++; $display("FAIL sb1_unexpected_write: got din=%h, want no write", fifo_din1);
            end else begin
                exp_b = q1.pop_front();
                if (fifo_din1 !== exp_b) begin errors++; $display("FAIL sb1_byte: got %h, want %h", fifo_din1, exp_b); end
            end
        end
        if (fifo_write2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++; $display("FAIL sb2_unexpected_write: got din=%h, want no write", fifo_din2);
            end else begin
                exp_b = q2.pop_front();
                if (fifo_din2 !== exp_b) begin errors++; $display("FAIL sb2_byte: got %h, want %h", fifo_din2, exp_b); end
            end
        end
    endtask

    // Start a request in cycle 0; it is accepted at the edge that ends cycle 0.
    task automatic issue(input int n, input int which);
        @(posedge clk);
        #1;
        clear_obs();
        sel = which;
        if (which == 0) begin start = 1'b1; num_bytes = LEN_W'(n); end
        else begin start2 = 1'b1; num_bytes2 = LEN_W'(n); end
        for (int k = 0; k < n; k++) begin
            if (which == 0) q1.push_back(exp_byte(W, k));
            else q2.push_back(exp_byte(WD, k));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; num_bytes = '0; num_bytes2 = '0;
        fifo_condition = 2'b00; ks = 64'h0; hold_start = 0; sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (core_load1 !== 1'b0) begin errors++; $display("FAIL rst_core_load: got %b, want 0", core_load1); end
        checks++; if (core_en1 !== 1'b0) begin errors++; $display("FAIL rst_core_en: got %b, want 0", core_en1); end
        checks++; if (fifo_write1 !== 1'b0) begin errors++; $display("FAIL rst_fifo_write: got %b, want 0", fifo_write1); end
        checks++; if (fifo_din1 !== 8'h00) begin errors++; $display("FAIL rst_fifo_din: got %h, want 00", fifo_din1); end
        checks++; if ({busy1, done1} !== 2'b00) begin errors++; $display("FAIL rst_busy_done: got %b, want 00", {busy1, done1}); end
        checks++; if (bytes_out1 !== '0) begin errors++; $display("FAIL rst_bytes_out: got %0d, want 0", bytes_out1); end
        checks++; if ({busy2, core_en2, fifo_write2} !== 3'b000) begin errors++; $display("FAIL rst_dut_def: got %b, want 000", {busy2, core_en2, fifo_write2}); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single();
        ks = 64'h0000_0000_0000_04D0;
        issue(1, 0);
        repeat (20) tick();
        checks++; if (first_load != 1 || n_load != 1) begin errors++; $display("FAIL single_load: got cycle %0d x%0d, want cycle 1 x1", first_load, n_load); end
        checks++; if (first_en != 2) begin errors++; $display("FAIL single_first_en: got %0d, want 2", first_en); end
        checks++; if (en_before_wr != W + 8 || n_en != W + 8) begin errors++; $display("FAIL single_en_count: got %0d/%0d, want %0d", en_before_wr, n_en, W + 8); end
        checks++; if (first_wr != 14 || n_wr != 1) begin errors++; $display("FAIL single_write: got cycle %0d x%0d, want cycle 14 x1", first_wr, n_wr); end
        checks++; if (din_first !== 8'h4D) begin errors++; $display("FAIL single_din: got %h, want 4d", din_first); end
        checks++; if (first_done != 15 || n_done != 1) begin errors++; $display("FAIL single_done: got cycle %0d x%0d, want cycle 15 x1", first_done, n_done); end
        checks++; if (bytes_out1 !== 16'd1) begin errors++; $display("FAIL single_bytes_out: got %0d, want 1", bytes_out1); end
        checks++; if (q1.size() != 0) begin errors++; $display("FAIL single_sb_left: got %0d pending, want 0", q1.size()); end
    endtask

    task automatic test_stall();
        ks = 64'hA5C3_1E97_6B2D_F048;
        issue(3, 0);
        stall_lo = 23; stall_hi = 27;
        repeat (45) tick();
        checks++; if (n_wr != 3) begin errors++; $display("FAIL stall_writes: got %0d, want 3", n_wr); end
        checks++; if (first_wr != 14 || second_wr != 28 || last_wr != 37) begin errors++; $display("FAIL stall_write_cycles: got %0d,%0d,%0d, want 14,28,37", first_wr, second_wr, last_wr); end
        checks++; if (en_in_stall != 0) begin errors++; $display("FAIL stall_core_en: got %0d en cycles, want 0", en_in_stall); end
        checks++; if (din_changes != 0) begin errors++; $display("FAIL stall_din_hold: got %0d changes, want 0", din_changes); end
        checks++; if (n_done != 1 || first_done != 38) begin errors++; $display("FAIL stall_done: got cycle %0d x%0d, want cycle 38 x1", first_done, n_done); end
        checks++; if (bytes_out1 !== 16'd3) begin errors++; $display("FAIL stall_bytes_out: got %0d, want 3", bytes_out1); end
        checks++; if (q1.size() != 0) begin errors++; $display("FAIL stall_sb_left: got %0d pending, want 0", q1.size()); end
    endtask

    task automatic test_zero();
        issue(0, 0);
        repeat (6) tick();
        checks++; if (first_done != 1 || n_done != 1) begin errors++; $display("FAIL zero_done: got cycle %0d x%0d, want cycle 1 x1", first_done, n_done); end
        checks++; if (n_load != 0 || n_en != 0 || n_wr != 0) begin errors++; $display("FAIL zero_activity: got load=%0d en=%0d wr=%0d, want 0", n_load, n_en, n_wr); end
        checks++; if (n_busy != 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles, want 0", n_busy); end
    endtask

    task automatic test_reset_mid();
        ks = 64'h3C5A_96F0_0FE1_7B24;
        issue(1, 0);
        repeat (3) tick();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({core_load1, core_en1, fifo_write1, busy1, done1} !== 5'b00000) begin errors++; $display("FAIL rstmid_ctrl: got %b, want 00000", {core_load1, core_en1, fifo_write1, busy1, done1}); end
        checks++; if (fifo_din1 !== 8'h00 || bytes_out1 !== '0) begin errors++; $display("FAIL rstmid_data: got din=%h bytes=%0d, want 00/0", fifo_din1, bytes_out1); end
        q1.delete();
        clear_obs();
        repeat (15) tick();
        checks++; if (n_en != 0 || n_wr != 0 || n_busy != 0) begin errors++; $display("FAIL rstmid_quiet: got en=%0d wr=%0d busy=%0d, want 0", n_en, n_wr, n_busy); end
        issue(1, 0);
        repeat (20) tick();
        checks++; if (first_load != 1 || first_en != 2) begin errors++; $display("FAIL rstmid_reload: got load@%0d en@%0d, want 1/2", first_load, first_en); end
        checks++; if (en_before_wr != W + 8 || first_wr != 14) begin errors++; $display("FAIL rstmid_warmup: got en=%0d wr@%0d, want %0d/14", en_before_wr, first_wr, W + 8); end
        checks++; if (n_done != 1 || q1.size() != 0) begin errors++; $display("FAIL rstmid_done: got done=%0d pending=%0d, want 1/0", n_done, q1.size()); end
    endtask

    task automatic test_ignore_start();
        ks = 64'h1234_5678_9ABC_DEF0;
        issue(2, 0);
        repeat (7) tick();
        start = 1'b1; num_bytes = 16'd5;
        repeat (20) tick();
        checks++; if (n_load != 1) begin errors++; $display("FAIL ignore_load: got %0d loads, want 1", n_load); end
        checks++; if (n_wr != 2 || second_wr != 23) begin errors++; $display("FAIL ignore_writes: got %0d, 2nd@%0d, want 2, 2nd@23", n_wr, second_wr); end
        checks++; if (n_done != 1 || first_done != 24) begin errors++; $display("FAIL ignore_done: got cycle %0d x%0d, want cycle 24 x1", first_done, n_done); end
        checks++; if (bytes_out1 !== 16'd2) begin errors++; $display("FAIL ignore_bytes_out: got %0d, want 2", bytes_out1); end
    endtask

    task automatic test_back_to_back();
        ks = 64'hF0E1_D2C3_B4A5_9687;
        issue(1, 0);
        q1.push_back(exp_byte(W, 0));
        hold_start = 1;
        while (cyc < 16) tick();
        hold_start = 0;
        repeat (24) tick();
        checks++; if (n_load != 2 || last_load != 17) begin errors++; $display("FAIL b2b_load: got %0d loads, last@%0d, want 2, last@17", n_load, last_load); end
        checks++; if (n_wr != 2 || second_wr != 30) begin errors++; $display("FAIL b2b_writes: got %0d, 2nd@%0d, want 2, 2nd@30", n_wr, second_wr); end
        checks++; if (n_done != 2 || q1.size() != 0) begin errors++; $display("FAIL b2b_done: got done=%0d pending=%0d, want 2/0", n_done, q1.size()); end
    endtask

    task automatic test_default();
        ks = 64'h9D2C_5680_B1F3_4E7A;
        issue(2, 1);
        repeat (1180) tick();
        checks++; if (first_en != 2) begin errors++; $display("FAIL def_first_en: got %0d, want 2", first_en); end
        checks++; if (en_before_wr != WD + 8) begin errors++; $display("FAIL def_en_count: got %0d, want %0d", en_before_wr, WD + 8); end
        checks++; if (first_wr != WD + 10 || second_wr != WD + 19) begin errors++; $display("FAIL def_writes: got %0d,%0d, want %0d,%0d", first_wr, second_wr, WD + 10, WD + 19); end
        checks++; if (n_done != 1 || first_done != WD + 20) begin errors++; $display("FAIL def_done: got cycle %0d x%0d, want cycle %0d x1", first_done, n_done, WD + 20); end
        checks++; if (bytes_out2 !== 16'd2 || q2.size() != 0) begin errors++; $display("FAIL def_bytes: got %0d pending=%0d, want 2/0", bytes_out2, q2.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_zero();
        test_reset_mid();
        test_ignore_start();
        test_back_to_back();
        test_default();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
